// File: rtl/fp_8_to_16_multiplier.sv
// fp_8_to_16_multiplier: OCP E4M3 x E4M3 -> IEEE-754 binary16 product, one
// registered stage. The product is exact except on overflow.
// Optional macro FP8_MUL_SATURATE_EN: overflow yields +/-65504 instead of +/-Inf.
module fp_8_to_16_multiplier (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  fp_data_1,
    input  logic [7:0]  fp_data_2,
    output logic [15:0] data_out
);

`ifdef FP8_MUL_SATURATE_EN
    localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
    localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif
    localparam logic [15:0] QNAN = 16'h7E00;

    logic [3:0]        e_1, e_2;
    logic [2:0]        m_1, m_2;
    logic              nan_1, nan_2, zero_1, zero_2;
    logic [3:0]        sig_1, sig_2;
    logic [7:0]        prod;
    logic signed [6:0] exp_1, exp_2, exp_sum, exp_res;
    logic [2:0]        lead;
    logic [6:0]        frac;
    logic [6:0]        sub_shift;
    logic [9:0]        sub_mant;
    logic [4:0]        e_out;
    logic              sign_out;
    logic [15:0]       result;

    assign e_1    = fp_data_1[6:3];
    assign e_2    = fp_data_2[6:3];
    assign m_1    = fp_data_1[2:0];
    assign m_2    = fp_data_2[2:0];
    assign nan_1  = &fp_data_1[6:0];
    assign nan_2  = &fp_data_2[6:0];
    assign zero_1 = ~|fp_data_1[6:0];
    assign zero_2 = ~|fp_data_2[6:0];

    // Hidden bit is set for normals; subnormals share the exponent of e==1.
    assign sig_1 = {|e_1, m_1};
    assign sig_2 = {|e_2, m_2};
    assign prod  = {4'b0000, sig_1} * {4'b0000, sig_2};

    assign exp_1   = (e_1 == 4'd0) ? -7'sd6 : $signed({3'b000, e_1}) - 7'sd7;
    assign exp_2   = (e_2 == 4'd0) ? -7'sd6 : $signed({3'b000, e_2}) - 7'sd7;
    assign exp_sum = exp_1 + exp_2;

    // Leading-one detect over the 8-bit product (6 fraction bits).
    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (prod[i]) lead = 3'(i);
        end
    end

    assign exp_res = exp_sum - 7'sd6 + $signed({4'b0000, lead});
    assign frac    = 7'(prod << (3'd7 - lead));
    assign e_out   = 5'(exp_res + 7'sd15);

    // FP16 subnormal mantissa is value * 2^24 = prod << (exp_sum + 18); the
    // shift is never negative since exp_sum >= -12.
    assign sub_shift = exp_sum + 7'sd18;
    assign sub_mant  = 10'({8'b0000_0000, prod} << sub_shift);

    // Special-case priority: NaN, zero, overflow, subnormal, normal.
    always_comb begin
        sign_out = fp_data_1[7] ^ fp_data_2[7];
        result   = '0;
        if (nan_1 || nan_2)
            result = QNAN;
        else if (zero_1 || zero_2)
            result = {sign_out, 15'h0000};
        else if (exp_res > 7'sd15)
            result = {sign_out, OVF_MAG};
        else if (exp_res < -7'sd14)
            result = {sign_out, 5'b00000, sub_mant};
        else
            result = {sign_out, e_out, frac, 3'b000};
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn)
            data_out <= '0;
        else
            data_out <= result;
    end

endmodule

// File: tb/tb_fp_8_to_16_multiplier.sv
// Bench for fp_8_to_16_multiplier: directed table, reset sequences, back-to-back
// stream and an exhaustive sweep against a real-number reference model.
module tb_fp_8_to_16_multiplier;

`ifdef FP8_MUL_SATURATE_EN
    localparam logic [15:0] OVF_P = 16'h7BFF;
    localparam logic [15:0] OVF_N = 16'hFBFF;
`else
    localparam logic [15:0] OVF_P = 16'h7C00;
    localparam logic [15:0] OVF_N = 16'hFC00;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  fp_data_1 = '0;
    logic [7:0]  fp_data_2 = '0;
    logic [15:0] data_out;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        string       tag;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];
    int   total = 0;
    int   bad   = 0;

    fp_8_to_16_multiplier dut (
        .clk       (clk),
        .rstn      (rstn),
        .fp_data_1 (fp_data_1),
        .fp_data_2 (fp_data_2),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp8_mag(input logic [7:0] v);
        int e = int'(v[6:3]);
        int m = int'(v[2:0]);
        if (e == 0) return real'(m) * pow2(-9);
        return real'(8 + m) * pow2(e - 10);
    endfunction

    // Reference: exact product in real arithmetic, then encoded to binary16.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        logic        s;
        real         mag;
        int          x;
        int          q;
        logic [9:0]  mant;
        logic [4:0]  ex;
        s = a[7] ^ b[7];
        if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) return 16'h7E00;
        if (a[6:0] == 7'h00 || b[6:0] == 7'h00) return {s, 15'h0000};
        mag = fp8_mag(a) * fp8_mag(b);
        if (mag >= 65536.0) return s ? OVF_N : OVF_P;
        if (mag < pow2(-14)) begin
            q    = $rtoi(mag * pow2(24));
            mant = q[9:0];
            return {s, 5'b00000, mant};
        end
        x = -14;
        while (mag >= pow2(x + 1)) x++;
        q    = $rtoi((mag * pow2(-x) - 1.0) * 1024.0);
        mant = q[9:0];
        q    = x + 15;
        ex   = q[4:0];
        return {s, ex, mant};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic r,
                         input logic [15:0] e, input string t);
        @(negedge clk);
        fp_data_1 = a;
        fp_data_2 = b;
        rstn      = r;
        sb.push_back('{a, b, e, t});
    endtask

    // Every edge that follows a driven pair has exactly one expected result.
    always @(posedge clk) begin
        vec_t v;
        if (sb.size() > 0) begin
            v = sb.pop_front();
            #1;
            total++;
            if (data_out !== v.exp) begin
                bad++;
                $display("FAIL %s a=%h b=%h got=%h want=%h", v.tag, v.a, v.b, data_out, v.exp);
            end
        end
    end

    initial begin
        tbl[0] = '{8'h38, 8'h38, 16'h3C00, "one_x_one"};
        tbl[1] = '{8'h3C, 8'h3C, 16'h4080, "1p5_sq"};
        tbl[2] = '{8'h40, 8'hC4, 16'hC600, "two_x_m3"};
        tbl[3] = '{8'hB8, 8'h00, 16'h8000, "neg_zero"};
        tbl[4] = '{8'h01, 8'h01, 16'h0040, "sub_sub"};
        tbl[5] = '{8'h01, 8'h08, 16'h0200, "sub_min_norm"};
        tbl[6] = '{8'h7E, 8'h7E, OVF_P,    "ovf_pos"};
        tbl[7] = '{8'hFE, 8'h7E, OVF_N,    "ovf_neg"};
        tbl[8] = '{8'h7F, 8'h38, 16'h7E00, "nan_x_one"};
        tbl[9] = '{8'hFF, 8'h00, 16'h7E00, "nan_x_zero"};

        // Reset held for two edges with live operands, then released.
        drive(8'h38, 8'h38, 1'b0, 16'h0000, "rst_hold0");
        drive(8'h38, 8'h38, 1'b0, 16'h0000, "rst_hold1");
        drive(8'h38, 8'h38, 1'b1, 16'h3C00, "rst_release");

        // Directed table, applied back to back.
        for (int i = 0; i < 10; i++)
            drive(tbl[i].a, tbl[i].b, 1'b1, tbl[i].exp, tbl[i].tag);

        // Reset dropped mid-stream for one edge.
        drive(8'h3C, 8'h3C, 1'b1, 16'h4080, "mid_pre");
        drive(8'h3C, 8'h3C, 1'b0, 16'h0000, "mid_rst");
        drive(8'h40, 8'hC4, 1'b1, 16'hC600, "mid_post");

        // Idle gap (no results expected), then a varied back-to-back burst.
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            drive(a, b, 1'b1, model(a, b), "burst");
        end

        // Exhaustive sweep of all operand pairs.
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] pair;
            pair = 16'(i);
            drive(pair[15:8], pair[7:0], 1'b1, model(pair[15:8], pair[7:0]), "exh");
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
